one_x_four_demux: RTL
=====================

Name: one_x_four_demux

Overview:
- Registered 1:4 demultiplexer for the 8-bit datapath. It steers one source byte to one of four destination lanes selected by a 2-bit code.
- Each lane has a one-entry output register and a valid/ready handshake, so a slow destination stalls only writes aimed at it.
- It is the write-side counterpart of the 4:1 operand select. It fans ALU/bus results out to four destinations: register bank, output port, memory data register, accumulator.

Parameters:
- WIDTH, 8, data width of input and of each lane.
- CNT_W, 8, width of each per-lane statistics counter (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  source presents a byte.
- in_sel  input  2  destination lane: 00→lane0, 01→lane1, 10→lane2, 11→lane3.
- in_data  input  WIDTH  byte to route.
- in_ready  output  1  selected lane can accept this cycle.
- out_valid  output  4  bit k: lane k register holds data.
- out_ready  input  4  bit k: lane k destination consumes data.
- out_data  output  4*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- stat_cnt  output  4*CNT_W  lane k accepted-write count, bits [k*CNT_W +: CNT_W].

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge): out_valid=0000, all out_data lanes=0, all stat_cnt=0.
  - rst overrides any same-cycle transfer; in-flight lane contents are discarded.
  - in_ready is combinational, so it is 1 right after reset for any in_sel.
- in_ready = ~out_valid[in_sel] | out_ready[in_sel].
  - It is purely combinational from in_sel, out_valid and out_ready.
  - It does not depend on in_valid.
- Accept: in_valid & in_ready at an edge.
  - Effect: lane[in_sel] data ← in_data and out_valid[in_sel] ← 1.
  - Latency: 1 cycle. A byte accepted at edge N is visible on out_data/out_valid from edge N onward, i.e. in cycle N+1.
- Drain: out_valid[k] & out_ready[k] at an edge clears out_valid[k], unless the same edge writes lane k.
- Simultaneous drain and write on the same lane: new data loaded, out_valid[k] stays 1 (full throughput, one byte per cycle per lane).
- Write to lane j and drain of lane k≠j in the same cycle: both take effect independently.
- Stall: out_valid[k]=1 & out_ready[k]=0 holds lane k data stable. A source targeting lane k sees in_ready=0. Other lanes are unaffected.
- Lane data does not change except on an accepted write or reset. out_data lanes keep their last value after draining; they are not zeroed.
- in_sel and in_data may change freely while in_valid=1 and in_ready=0. No stability rule is imposed on the source; in_ready tracks the current in_sel.
- in_valid=0: no lane state changes except drains.
- Only one lane is written per cycle; the block has no internal FSM beyond the four valid flags.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - Per-lane CNT_W-bit counter increments on each accepted write to that lane.
  - It saturates at 2^CNT_W-1 (no wrap) and clears only on rst.
  - Counters are driven on stat_cnt.
- Not defined: no counter registers are synthesised; stat_cnt is tied to all zeros. Port list is identical either way.

Test Plan:
1. Reset: hold rst=1 two cycles with in_valid=1, in_sel=10, in_data=8'hA5 → out_valid=0000, all lanes 0, stat_cnt=0; in_ready=1 after release.
2. Single route: in_sel=01, in_data=8'h3C, in_valid=1 one cycle, out_ready=0000 → next cycle out_valid=0010, lane1=8'h3C; a second write to lane1 sees in_ready=0 and lane1 stays 8'h3C.
3. Independent lanes: lane1 full and stalled; write 8'h11 to lane0, then 8'h22 to lane3 → in_ready=1 both times, out_valid=1011, lane0=8'h11, lane3=8'h22, lane1 still 8'h3C.
4. Back-to-back throughput: out_ready[2]=1 constantly; stream 8'h01..8'h08 to lane2 on consecutive cycles → in_ready held 1, lane2 shows 01..08 one per cycle, out_valid[2] stays 1 until a cycle after the last byte.
5. Mid-operation reset: lanes 0 and 3 full and stalled, assert rst for one cycle simultaneous with an accepted write to lane2 → out_valid=0000 afterwards, lane2=0 (write discarded).
6. Stats (DEMUX_STATS_EN defined, CNT_W=8): 300 accepted writes to lane3, 5 to lane0 → lane3 count=8'hFF (saturated), lane0=5, lanes1/2=0; same stimulus without the macro → stat_cnt=0.

Source files
------------

// File: rtl/one_x_four_demux.sv
// Registered 1:4 demultiplexer: routes one byte per cycle to one of four lanes,
// each with its own one-entry output register and valid/ready handshake.
// Optional per-lane saturating write counters are enabled by defining DEMUX_STATS_EN.
module one_x_four_demux #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [1:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [4*CNT_W-1:0]   stat_cnt
);

    logic [3:0] wr_en;

    // A full lane can still accept when its destination drains on the same edge.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;

            assign wr_en[gi] = in_valid & in_ready & (in_sel == 2'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (wr_en[gi]) begin
                    valid_reg <= 1'b1;
                    data_reg  <= in_data;
                end else if (out_ready[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign out_valid[gi]                  = valid_reg;
            assign out_data[gi*WIDTH +: WIDTH]    = data_reg;

`ifdef DEMUX_STATS_EN
            logic [CNT_W-1:0] cnt_reg;

            // Saturates rather than wrapping so a long run never reads as a small count.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (wr_en[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign stat_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
`else
            assign stat_cnt[gi*CNT_W +: CNT_W] = '0;
`endif
        end
    endgenerate

endmodule
